// File: rtl/fdiv_pkg.sv
// Shared types and FP16 helpers for the divider arbiter.
//   state_t        : arbiter FSM states
//   FP16_*         : half-precision constants used by the zero-divisor bypass
//   is_zero/is_nan : FP16 classification helpers
package fdiv_pkg;

  localparam int          FP16_W    = 16;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [14:0] FP16_INF  = 15'h7C00;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT_Z = 3'd3,
    RESP   = 3'd4
  } state_t;

  function automatic logic is_zero(input logic [15:0] x);
    return x[14:0] == 15'd0;
  endfunction

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index of the last winner; search starts at ptr+1
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : index of the granted bit
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDXW-1:0]    gnt_idx
);

  logic found;
  int   j;

  // Walk ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the last winner is tried last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/fdiv_arbiter.sv
// Shares one fp16 divider between NUM_REQ requesters.
// Round-robin grant, operand latch, then divider handshakes a -> b -> z,
// and the quotient is returned to the owner on a valid/ready channel.
//   clk, rst_n                 : clock, async active-low reset
//   req_a/req_b/req_stb/req_ack: per-requester operand channel
//   resp_z/resp_valid/resp_ready: result channel (shared data bus)
//   grant_idx, busy            : current owner, non-IDLE flag
//   div_*                      : handshakes to the single divider
// Optional: FDIV_ARB_ZERO_BYPASS_EN answers x/±0 locally (±inf or qNaN)
// without touching the divider.
module fdiv_arbiter
  import fdiv_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = 16,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ*DW-1:0] req_a,
  input  logic [NUM_REQ*DW-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_stb,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [DW-1:0]         resp_z,
  output logic [NUM_REQ-1:0]    resp_valid,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [IDXW-1:0]       grant_idx,
  output logic                  busy,
  output logic [DW-1:0]         div_a,
  output logic                  div_a_stb,
  input  logic                  div_a_ack,
  output logic [DW-1:0]         div_b,
  output logic                  div_b_stb,
  input  logic                  div_b_ack,
  input  logic [DW-1:0]         div_z,
  input  logic                  div_z_stb,
  output logic                  div_z_ack
);

  state_t              state_q, state_d;
  logic [DW-1:0]       a_q, b_q, z_q;
  logic [IDXW-1:0]     ptr_q, gidx_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDXW-1:0]     arb_idx;
  logic [DW-1:0]       a_in, b_in;
  logic                take;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_rr (
    .req     (req_stb),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign a_in = req_a[int'(arb_idx)*DW +: DW];
  assign b_in = req_b[int'(arb_idx)*DW +: DW];
  // New requests are only looked at in IDLE; later stb changes are ignored.
  assign take = (state_q == IDLE) && (|req_stb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (take) begin
`ifdef FDIV_ARB_ZERO_BYPASS_EN
        state_d = is_zero(b_in) ? RESP : SEND_A;
`else
        state_d = SEND_A;
`endif
      end
      SEND_A:  if (div_a_ack) state_d = SEND_B;
      SEND_B:  if (div_b_ack) state_d = WAIT_Z;
      WAIT_Z:  if (div_z_stb) state_d = RESP;
      RESP:    if (resp_ready[gidx_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      z_q    <= '0;
      gidx_q <= '0;
      ptr_q  <= IDXW'(NUM_REQ - 1);
      ack_q  <= '0;
    end else begin
      ack_q <= '0;
      if (take) begin
        a_q    <= a_in;
        b_q    <= b_in;
        gidx_q <= arb_idx;
        ptr_q  <= arb_idx;
        ack_q  <= arb_gnt;
`ifdef FDIV_ARB_ZERO_BYPASS_EN
        if (is_zero(b_in))
          z_q <= (is_zero(a_in) || is_nan(a_in)) ? FP16_QNAN
                                                 : {a_in[15] ^ b_in[15], FP16_INF};
`endif
      end
      if (state_q == WAIT_Z && div_z_stb) z_q <= div_z;
    end
  end

  always_comb begin
    req_ack    = ack_q;
    grant_idx  = gidx_q;
    resp_z     = z_q;
    div_a      = a_q;
    div_b      = b_q;
    busy       = (state_q != IDLE);
    div_a_stb  = (state_q == SEND_A);
    div_b_stb  = (state_q == SEND_B);
    div_z_ack  = (state_q == WAIT_Z);
    resp_valid = '0;
    if (state_q == RESP) resp_valid[gidx_q] = 1'b1;
  end

endmodule

// File: tb/tb_fdiv_arbiter.sv
// Directed bench for fdiv_arbiter: the bench plays both the requesters and
// the divider, supplying hand-computed quotients.
module tb_fdiv_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] req_a, req_b;
  logic [N-1:0]    req_stb, req_ack, resp_valid, resp_ready;
  logic [DW-1:0]   resp_z, div_a, div_b, div_z;
  logic [1:0]      grant_idx;
  logic            busy, div_a_stb, div_a_ack, div_b_stb, div_b_ack;
  logic            div_z_stb, div_z_ack;
  logic [15:0]     ra[N], rb[N];

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = ra[i];
      req_b[i*DW +: DW] = rb[i];
    end
  end

  fdiv_arbiter #(.NUM_REQ(N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .resp_z(resp_z), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .grant_idx(grant_idx), .busy(busy),
    .div_a(div_a), .div_a_stb(div_a_stb), .div_a_ack(div_a_ack),
    .div_b(div_b), .div_b_stb(div_b_stb), .div_b_ack(div_b_ack),
    .div_z(div_z), .div_z_stb(div_z_stb), .div_z_ack(div_z_ack)
  );

  typedef struct {
    int          raise;          // requester to raise first (-1: none)
    logic [15:0] a, b;
    int          g;              // expected grant to serve (-1: none)
    logic [15:0] ea, eb, z;
    int          adly, rdly;     // div_a_ack delay, resp_ready delay
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int g);
    int n;
    logic [N-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (req_ack == '0 && n < 20);
    chk("ack_latency", 32'(n), 32'd1);
    chk("req_ack", 32'(req_ack), 32'(oh));
    chk("grant_idx", 32'(grant_idx), 32'(g));
    req_stb[g] = 1'b0;
  endtask

  task automatic do_op(input int g, input logic [15:0] ea, input logic [15:0] eb,
                       input logic [15:0] z, input int adly, input int rdly);
    logic [N-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    wait_ack(g);
    chk("a_stb", 32'(div_a_stb), 32'd1);
    chk("div_a", 32'(div_a), 32'(ea));
    chk("b_stb_early", 32'(div_b_stb), 32'd0);
    for (int i = 0; i < adly; i++) begin
      tick();
      chk("a_stb_hold", 32'(div_a_stb), 32'd1);
      chk("div_a_hold", 32'(div_a), 32'(ea));
      chk("b_stb_hold", 32'(div_b_stb), 32'd0);
      chk("req_ack_pulse", 32'(req_ack), 32'd0);
    end
    div_a_ack = 1'b1;
    tick();
    div_a_ack = 1'b0;
    chk("a_stb_drop", 32'(div_a_stb), 32'd0);
    chk("b_stb", 32'(div_b_stb), 32'd1);
    chk("div_b", 32'(div_b), 32'(eb));
    div_b_ack = 1'b1;
    tick();
    div_b_ack = 1'b0;
    chk("b_stb_drop", 32'(div_b_stb), 32'd0);
    chk("z_ack", 32'(div_z_ack), 32'd1);
    chk("resp_valid_early", 32'(resp_valid), 32'd0);
    div_z     = z;
    div_z_stb = 1'b1;
    tick();
    div_z_stb = 1'b0;
    chk("z_ack_drop", 32'(div_z_ack), 32'd0);
    chk("resp_valid", 32'(resp_valid), 32'(oh));
    chk("resp_z", 32'(resp_z), 32'(z));
    for (int i = 0; i < rdly; i++) begin
      resp_ready = ~oh;            // others' ready must be ignored
      tick();
      chk("resp_valid_hold", 32'(resp_valid), 32'(oh));
      chk("no_new_grant", 32'(req_ack), 32'd0);
      chk("owner_hold", 32'(grant_idx), 32'(g));
    end
    resp_ready = oh;
    tick();
    resp_ready = '0;
    chk("resp_valid_clr", 32'(resp_valid), 32'd0);
    chk("idle_gap", 32'(busy), 32'd0);
  endtask

  task automatic raise(input int r, input logic [15:0] a, input logic [15:0] b);
    ra[r] = a;
    rb[r] = b;
    req_stb[r] = 1'b1;
  endtask

`ifdef FDIV_ARB_ZERO_BYPASS_EN
  task automatic bypass_op(input int g, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] z);
    logic [N-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    raise(g, a, b);
    wait_ack(g);
    chk("bp_resp_valid", 32'(resp_valid), 32'(oh));
    chk("bp_resp_z", 32'(resp_z), 32'(z));
    chk("bp_no_a_stb", 32'(div_a_stb), 32'd0);
    chk("bp_no_b_stb", 32'(div_b_stb), 32'd0);
    chk("bp_no_z_ack", 32'(div_z_ack), 32'd0);
    resp_ready = oh;
    tick();
    resp_ready = '0;
    chk("bp_clr", 32'(resp_valid), 32'd0);
    chk("bp_no_a_stb_after", 32'(div_a_stb), 32'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{0, 16'h3C00, 16'h4000, -1, 16'h0, 16'h0, 16'h0, 0, 0};
    tbl[1]  = '{1, 16'h3C00, 16'h4000, -1, 16'h0, 16'h0, 16'h0, 0, 0};
    tbl[2]  = '{2, 16'h3C00, 16'h4000, -1, 16'h0, 16'h0, 16'h0, 0, 0};
    tbl[3]  = '{3, 16'h3C00, 16'h4000,  0, 16'h3C00, 16'h4000, 16'h3800, 0, 0};
    tbl[4]  = '{-1, 16'h0, 16'h0,       1, 16'h3C00, 16'h4000, 16'h3800, 0, 0};
    tbl[5]  = '{-1, 16'h0, 16'h0,       2, 16'h3C00, 16'h4000, 16'h3800, 0, 0};
    tbl[6]  = '{-1, 16'h0, 16'h0,       3, 16'h3C00, 16'h4000, 16'h3800, 0, 0};
    tbl[7]  = '{2, 16'h4200, 16'h4000, -1, 16'h0, 16'h0, 16'h0, 0, 0};
    tbl[8]  = '{0, 16'h4400, 16'h4000,  0, 16'h4400, 16'h4000, 16'h4000, 0, 0};
    tbl[9]  = '{-1, 16'h0, 16'h0,       2, 16'h4200, 16'h4000, 16'h3E00, 0, 0};
    tbl[10] = '{0, 16'h4200, 16'h3E00,  0, 16'h4200, 16'h3E00, 16'h4000, 5, 0};
    tbl[11] = '{3, 16'h3C00, 16'h3C00, -1, 16'h0, 16'h0, 16'h0, 0, 0};
    tbl[12] = '{1, 16'h4600, 16'h4000,  1, 16'h4600, 16'h4000, 16'h4200, 0, 10};
    tbl[13] = '{-1, 16'h0, 16'h0,       3, 16'h3C00, 16'h3C00, 16'h3C00, 0, 0};

    rst_n = 1'b0;
    req_stb = '0; resp_ready = '0;
    div_a_ack = 1'b0; div_b_ack = 1'b0; div_z_stb = 1'b0; div_z = '0;
    for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; end

    repeat (2) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ack", 32'(req_ack), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_div_stb", 32'({div_a_stb, div_b_stb, div_z_ack}), 32'd0);
    chk("rst_grant_idx", 32'(grant_idx), 32'd0);
    chk("rst_resp_z", 32'(resp_z), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].raise >= 0) raise(tbl[i].raise, tbl[i].a, tbl[i].b);
      if (tbl[i].g >= 0)
        do_op(tbl[i].g, tbl[i].ea, tbl[i].eb, tbl[i].z, tbl[i].adly, tbl[i].rdly);
    end

    // Reset while waiting on the divider result.
    raise(2, 16'h4200, 16'h3E00);
    wait_ack(2);
    div_a_ack = 1'b1; tick(); div_a_ack = 1'b0;
    div_b_ack = 1'b1; tick(); div_b_ack = 1'b0;
    chk("mid_wait_z", 32'(div_z_ack), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_z_ack", 32'(div_z_ack), 32'd0);
    chk("mid_rst_div_a", 32'(div_a), 32'd0);
    chk("mid_rst_grant", 32'(grant_idx), 32'd0);
    tick();
    rst_n = 1'b1;
    div_z = 16'h1234;
    div_z_stb = 1'b1;
    tick();
    div_z_stb = 1'b0;
    tick();
    chk("no_stale_resp", 32'(resp_valid), 32'd0);
    chk("no_stale_busy", 32'(busy), 32'd0);
    raise(2, 16'h4200, 16'h4000);
    raise(0, 16'h4400, 16'h4000);
    do_op(0, 16'h4400, 16'h4000, 16'h4000, 0, 0);
    do_op(2, 16'h4200, 16'h4000, 16'h3E00, 0, 0);

`ifdef FDIV_ARB_ZERO_BYPASS_EN
    bypass_op(1, 16'hC200, 16'h0000, 16'hFC00);
    bypass_op(3, 16'h0000, 16'h8000, 16'h7E00);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
